// File: rtl/count_wrap_monitor_if.sv
// Bus between the up/down counter and its wrap monitor.
// The counter side drives the value and the clear, and the monitor side returns its status and event pulses.
interface count_wrap_monitor_if #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
);
    logic [WIDTH-1:0]  q_in;
    logic              clr_cnt;
    logic              dir;
    logic              dir_valid;
    logic              wrap_up;
    logic              wrap_down;
    logic              reversal;
    logic              jump;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output q_in, clr_cnt,
        input  dir, dir_valid, wrap_up, wrap_down, reversal, jump, wrap_cnt
    );

    modport slave (
        input  q_in, clr_cnt,
        output dir, dir_valid, wrap_up, wrap_down, reversal, jump, wrap_cnt
    );
endinterface

// File: rtl/count_wrap_monitor.sv
// Watches a free-running up/down counter value and infers its direction.
// It registers single-cycle wrap, reversal and jump pulses and keeps a saturating count of wraps.
module count_wrap_monitor #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) (
    input logic                 clk,
    input logic                 reset_n,
    count_wrap_monitor_if.slave mon
);
    typedef enum logic [1:0] {ST_INIT, ST_LOST, ST_UP, ST_DOWN} state_t;
    typedef enum logic [1:0] {CL_HOLD, CL_STEP_UP, CL_STEP_DN, CL_JUMP} cls_t;

    localparam logic [WIDTH-1:0]  MAX_VAL = '1;
    localparam logic [WIDTH-1:0]  ONE_VAL = WIDTH'(1);
    localparam logic [WRAP_W-1:0] CNT_MAX = '1;

    state_t            state;
    cls_t              cls;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  delta;
    logic              wrap_up_hit;
    logic              wrap_dn_hit;

    logic              dir_r;
    logic              dir_valid_r;
    logic              wrap_up_r;
    logic              wrap_down_r;
    logic              reversal_r;
    logic              jump_r;
    logic [WRAP_W-1:0] wrap_cnt_r;

    // Modular difference: a step across the max/0 boundary still reads as +/-1.
    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        delta = mon.q_in - prev;
        cls   = CL_JUMP;
        if (delta == '0)
            cls = CL_HOLD;
        else if (delta == ONE_VAL)
            cls = CL_STEP_UP;
        else if (delta == MAX_VAL)
            cls = CL_STEP_DN;
        wrap_up_hit = (cls == CL_STEP_UP) && (prev == MAX_VAL);
        wrap_dn_hit = (cls == CL_STEP_DN) && (prev == '0);
    end

    // NOTE: sequential state uses non-blocking assignments, so each register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_INIT;
            prev        <= '0;
            dir_r       <= 1'b0;
            dir_valid_r <= 1'b0;
            wrap_up_r   <= 1'b0;
            wrap_down_r <= 1'b0;
            reversal_r  <= 1'b0;
            jump_r      <= 1'b0;
            wrap_cnt_r  <= '0;
        end else begin
            prev        <= mon.q_in;
            wrap_up_r   <= 1'b0;
            wrap_down_r <= 1'b0;
            reversal_r  <= 1'b0;
            jump_r      <= 1'b0;

            if (state == ST_INIT) begin
                // First sample after reset only seeds prev; there is nothing to compare yet.
                state       <= ST_LOST;
                dir_valid_r <= 1'b0;
            end else begin
                unique case (cls)
                    CL_STEP_UP: begin
                        state       <= ST_UP;
                        dir_r       <= 1'b1;
                        dir_valid_r <= 1'b1;
                        reversal_r  <= (state == ST_DOWN);
                        wrap_up_r   <= wrap_up_hit;
                    end
                    CL_STEP_DN: begin
                        state       <= ST_DOWN;
                        dir_r       <= 1'b0;
                        dir_valid_r <= 1'b1;
                        reversal_r  <= (state == ST_UP);
                        wrap_down_r <= wrap_dn_hit;
                    end
                    CL_JUMP: begin
                        state       <= ST_LOST;
                        dir_valid_r <= 1'b0;
                        jump_r      <= 1'b1;
                    end
                    default: begin
                        state       <= state;
                        dir_valid_r <= (state == ST_UP) || (state == ST_DOWN);
                    end
                endcase
            end

            // A clear wins over a simultaneous wrap.
            if (mon.clr_cnt)
                wrap_cnt_r <= '0;
            else if ((state != ST_INIT) && (wrap_up_hit || wrap_dn_hit) && (wrap_cnt_r != CNT_MAX))
                wrap_cnt_r <= wrap_cnt_r + 1'b1;
        end
    end

    assign mon.dir       = dir_r;
    assign mon.dir_valid = dir_valid_r;
    assign mon.wrap_up   = wrap_up_r;
    assign mon.wrap_down = wrap_down_r;
    assign mon.reversal  = reversal_r;
    assign mon.jump      = jump_r;
    assign mon.wrap_cnt  = wrap_cnt_r;
endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor.
// Its expected values are worked out by hand from the value sequences it drives.
module tb_count_wrap_monitor;
    localparam int WIDTH  = 3;
    localparam int WRAP_W = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    count_wrap_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

    count_wrap_monitor #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mon     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic e_dir, input logic e_dv,
                             input logic e_wu, input logic e_wd, input logic e_rev,
                             input logic e_jmp, input int e_cnt);
        check({tag, ".dir"},       32'(bus.dir),       32'(e_dir));
        check({tag, ".dir_valid"}, 32'(bus.dir_valid), 32'(e_dv));
        check({tag, ".wrap_up"},   32'(bus.wrap_up),   32'(e_wu));
        check({tag, ".wrap_down"}, 32'(bus.wrap_down), 32'(e_wd));
        check({tag, ".reversal"},  32'(bus.reversal),  32'(e_rev));
        check({tag, ".jump"},      32'(bus.jump),      32'(e_jmp));
        check({tag, ".wrap_cnt"},  32'(bus.wrap_cnt),  32'(e_cnt));
    endtask

    // Drive inputs, then sample 1 ns after the rising edge that captures them.
    task automatic cyc(input int q, input logic clr);
        bus.q_in    = WIDTH'(q);
        bus.clr_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.q_in    = '0;
        bus.clr_cnt = 1'b0;
        #1;
        check_out("reset", 0, 0, 0, 0, 0, 0, 0);
        #11 reset_n = 1'b1;

        // Hold at 0: INIT then LOST, no events.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0);
            check_out($sformatf("hold%0d", i), 0, 0, 0, 0, 0, 0, 0);
        end

        // Ramp 1..7 up, then wrap 7 -> 0, then 1.
        for (int v = 1; v < 8; v++) begin
            cyc(v, 0);
            check_out($sformatf("ramp%0d", v), 1, 1, 0, 0, 0, 0, 0);
        end
        cyc(0, 0);
        check_out("wrap7to0", 1, 1, 1, 0, 0, 0, 1);
        cyc(1, 0);
        check_out("after_wrap", 1, 1, 0, 0, 0, 0, 1);

        // 2,3,4,5 then jump 5 -> 2, then down through 0 -> 7.
        for (int v = 2; v < 6; v++) begin
            cyc(v, 0);
            check_out($sformatf("up%0d", v), 1, 1, 0, 0, 0, 0, 1);
        end
        cyc(2, 0);
        check_out("jump5to2", 1, 0, 0, 0, 0, 1, 1);
        cyc(1, 0);
        check_out("dn1", 0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0);
        check_out("dn0", 0, 1, 0, 0, 0, 0, 1);
        cyc(7, 0);
        check_out("wrap0to7", 0, 1, 0, 1, 0, 0, 2);

        // 7 -> 4 jumps, then 5,6 up, 5,4 down: one reversal on 6 -> 5.
        cyc(4, 0);
        check_out("jump7to4", 0, 0, 0, 0, 0, 1, 2);
        cyc(5, 0);
        check_out("rv5", 1, 1, 0, 0, 0, 0, 2);
        cyc(6, 0);
        check_out("rv6", 1, 1, 0, 0, 0, 0, 2);
        cyc(5, 0);
        check_out("rv6to5", 0, 1, 0, 0, 1, 0, 2);
        cyc(4, 0);
        check_out("rv4", 0, 1, 0, 0, 0, 0, 2);

        // Saturation: 4 -> 7 jumps, then 300 alternating wraps 7<->0.
        cyc(7, 0);
        check_out("jump4to7", 0, 0, 0, 0, 0, 1, 2);
        cyc(0, 0);
        check_out("sat_first", 1, 1, 1, 0, 0, 0, 3);
        for (int i = 1; i < 300; i++) begin
            cyc((i % 2 == 0) ? 0 : 7, 0);
            if (i == 99) check("wrap_cnt_at_100", 32'(bus.wrap_cnt), 32'd102);
        end
        check_out("sat_last", 0, 1, 0, 1, 1, 0, 255);
        cyc(0, 1);
        check_out("clr_with_wrap", 1, 1, 1, 0, 1, 0, 0);
        cyc(7, 0);
        check_out("after_clr", 0, 1, 0, 1, 1, 0, 1);

        // Async reset mid-ramp, released between edges.
        cyc(0, 0);
        check_out("pre_rst_wrap", 1, 1, 1, 0, 1, 0, 2);
        cyc(1, 0);
        check_out("pre_rst_up", 1, 1, 0, 0, 0, 0, 2);
        #2 reset_n = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0, 0, 0, 0, 0);
        bus.q_in = 3'd5;
        @(posedge clk);
        #2 reset_n = 1'b1;
        cyc(5, 0);
        check_out("post_rst_first", 0, 0, 0, 0, 0, 0, 0);
        cyc(6, 0);
        check_out("post_rst_up", 1, 1, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
